// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the LTC2308 scan scheduler.
package adc_sched_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ADC_W  = 12;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN} sched_state_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            valid;
    logic            oneshot;
  } slot_t;

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// One-shot conversion request/response channel of the scan scheduler.
interface adc_scan_scheduler_if;
  import adc_sched_pkg::*;

  logic             req_valid;
  logic [CH_W-1:0]  req_chan;
  logic             req_ready;
  logic             resp_valid;
  logic [ADC_W-1:0] resp_data;
  logic             resp_err;

  modport master (
    output req_valid, req_chan,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_chan,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/adc_rr_pick.sv
// Round-robin pick: first set mask bit strictly after last, wrapping.
module adc_rr_pick
  import adc_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   pick,
  output logic              any
);

  logic [CH_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    // i = NUM_CH wraps back to last itself, so a lone bit at last is still found
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = last + CH_W'(i);
      if (!any && mask[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Channel sequencer for the LTC2308 interface: round-robin scan plus one-shot
// requests, with result attribution delayed one frame for the ADC pipeline.
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_rst_n,
  output logic [CH_W-1:0]   adc_chan,
  input  logic [ADC_W-1:0]  adc_result,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_chan,
  output logic [ADC_W-1:0]  smp_data,
  input  logic [CH_W-1:0]   rd_chan,
  output logic [ADC_W-1:0]  rd_data,
  adc_scan_scheduler_if.slave req
);

  localparam int unsigned       CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  sched_state_t     state, state_d;
  logic [CNT_W-1:0] cnt;
  slot_t            iss, pnd, pick_slot;
  logic [CH_W-1:0]  last_scan, rr_pick;
  logic             rr_any;
  logic             held;
  logic [CH_W-1:0]  held_ch;
  logic             frame_end, in_flight, accept;
  logic [ADC_W-1:0] result_q [NUM_CH];
  logic             resp_valid_q, resp_err_q;
  logic [ADC_W-1:0] resp_data_q;

  adc_rr_pick u_rr_pick (
    .mask (ch_mask),
    .last (last_scan),
    .pick (rr_pick),
    .any  (rr_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    frame_end = 1'b0;
    unique case (state)
      IDLE:  if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable) state_d = IDLE;
        else if (cnt == CNT_LAST) begin
          frame_end = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (!enable) state_d = IDLE;
        else if (cnt == CNT_LAST) frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_flight     = held | iss.oneshot | pnd.oneshot;
  assign req.req_ready = enable && (state != IDLE) && !in_flight;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    pick_slot = '0;
    if (held)        pick_slot = '{ch: held_ch, valid: 1'b1, oneshot: 1'b1};
    else if (rr_any) pick_slot = '{ch: rr_pick, valid: 1'b1, oneshot: 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      iss          <= '0;
      pnd          <= '0;
      last_scan    <= '0;
      held         <= 1'b0;
      held_ch      <= '0;
      adc_chan     <= '0;
      adc_rst_n    <= 1'b0;
      smp_valid    <= 1'b0;
      smp_chan     <= '0;
      smp_data     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      smp_valid    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      adc_rst_n    <= (state_d != IDLE);
      if (state_d == IDLE) begin
        if (in_flight) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_data_q  <= '0;
        end
        cnt       <= '0;
        iss       <= '0;
        pnd       <= '0;
        last_scan <= '0;
        held      <= 1'b0;
        adc_chan  <= '0;
      end else begin
        if (state == IDLE || cnt == CNT_LAST) cnt <= '0;
        else                                  cnt <= cnt + 1'b1;
        if (accept) begin
          held    <= 1'b1;
          held_ch <= req.req_chan;
        end
        if (frame_end) begin
          if (state == SCAN) begin
            if (pnd.valid) begin
              result_q[pnd.ch] <= adc_result;
              smp_valid        <= 1'b1;
              smp_chan         <= pnd.ch;
              smp_data         <= adc_result;
            end
            if (pnd.oneshot) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= adc_result;
            end
            pnd <= iss;
          end else begin
            // The ADC converts ch 0 during PRIME; keep it only if ch 0 is scanned
            pnd <= '{ch: '0, valid: ch_mask[0], oneshot: 1'b0};
          end
          iss      <= pick_slot;
          adc_chan <= pick_slot.ch;
          if (held)        held      <= 1'b0;
          else if (rr_any) last_scan <= rr_pick;
        end
      end
    end
  end

  assign rd_data        = result_q[rd_chan];
  assign req.resp_valid = resp_valid_q;
  assign req.resp_err   = resp_err_q;
  assign req.resp_data  = resp_data_q;

endmodule
